// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet instruction sequencer: inst field
// positions, the idle instruction word, address width and sequencer states.
package corelet_pkg;

    localparam int unsigned AW     = 11;
    localparam int unsigned INST_W = 34;

    // Bit positions inside the 34-bit inst word
    localparam int unsigned ACC_B      = 33;
    localparam int unsigned CEN_PMEM_B = 32;
    localparam int unsigned WEN_PMEM_B = 31;
    localparam int unsigned A_PMEM_MSB = 30;
    localparam int unsigned A_PMEM_LSB = 20;
    localparam int unsigned CEN_XMEM_B = 19;
    localparam int unsigned WEN_XMEM_B = 18;
    localparam int unsigned A_XMEM_MSB = 17;
    localparam int unsigned A_XMEM_LSB = 7;
    localparam int unsigned OFIFO_RD_B = 6;
    localparam int unsigned IFIFO_WR_B = 5;
    localparam int unsigned IFIFO_RD_B = 4;
    localparam int unsigned L0_RD_B    = 3;
    localparam int unsigned L0_WR_B    = 2;
    localparam int unsigned EXECUTE_B  = 1;
    localparam int unsigned LOAD_B     = 0;

    // Both SRAMs deselected and write-disabled, every strobe low
    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        StIdle,
        StWLoad,
        StWPush,
        StWSettle,
        StXLoad,
        StXExec,
        StDrain,
        StNext,
        StDone
    } seq_state_e;

endpackage

// File: rtl/corelet_seq_if.sv
// Handshake bundle between the sequencer (master) and the corelet side
// (slave): status flags in, instruction word and run status out.
interface corelet_seq_if;
    import corelet_pkg::*;

    logic              start;
    logic              l0_full;
    logic              ofifo_full;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, l0_full, ofifo_full, ofifo_valid,
        output inst, busy, done, err
    );

    modport slave (
        output start, l0_full, ofifo_full, ofifo_valid,
        input  inst, busy, done, err
    );

endinterface

// File: rtl/corelet_seq.sv
// Weight-stationary convolution sequencer. For every kernel index it loads
// weights into L0, pushes them into the array, lets them settle, streams the
// activations, then drains the output FIFO into pmem (accumulating for kij>0).
// The word on inst always belongs to (state_q, cnt_q); each edge advances the
// pair and registers the word for the new position.
module corelet_seq
    import corelet_pkg::*;
#(
    parameter int unsigned   row     = 8,
    parameter int unsigned   col     = 8,
    parameter int unsigned   len_kij = 9,
    parameter int unsigned   len_nij = 36,
    parameter logic [AW-1:0] w_base  = 11'd1024,
    parameter logic [AW-1:0] x_base  = 11'd0
) (
    input logic           clk,
    input logic           reset,
    corelet_seq_if.master seq_io
);

    localparam int unsigned KW = (len_kij > 1) ? $clog2(len_kij) : 1;

    localparam logic [AW-1:0] ColA        = AW'(col);
    localparam logic [AW-1:0] NijA        = AW'(len_nij);
    localparam logic [AW-1:0] WLoadLast   = AW'(col);
    localparam logic [AW-1:0] WPushLast   = AW'(col - 1);
    localparam logic [AW-1:0] WSettleLast = AW'(row + col - 1);
    localparam logic [AW-1:0] XLoadLast   = AW'(len_nij);
    localparam logic [AW-1:0] XExecLast   = AW'(len_nij - 1);
    localparam logic [KW-1:0] KijLast     = KW'(len_kij - 1);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;     // cycle index i within the phase
    logic [AW-1:0]     o_q, o_d;         // ofifo reads issued this drain
    logic [AW-1:0]     wcnt_q, wcnt_d;   // pmem writes issued this drain
    logic [KW-1:0]     kij_q, kij_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Next position in the sequence, then the instruction word for it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        wcnt_d  = wcnt_q;
        kij_d   = kij_q;
        err_d   = err_q;
        inst_d  = IDLE_INST;

        // Errors are only flagged; the sequence carries on regardless
        if (seq_io.l0_full && inst_q[L0_WR_B]) begin
            err_d = 1'b1;
        end
        if ((state_q == StXExec) && seq_io.ofifo_full) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (seq_io.start) begin
                    state_d = StWLoad;
                    cnt_d   = '0;
                    kij_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StWLoad: begin
                if (cnt_q == WLoadLast) begin
                    state_d = StWPush;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWPush: begin
                if (cnt_q == WPushLast) begin
                    state_d = StWSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWSettle: begin
                if (cnt_q == WSettleLast) begin
                    state_d = StXLoad;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StXLoad: begin
                if (cnt_q == XLoadLast) begin
                    state_d = StXExec;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StXExec: begin
                if (cnt_q == XExecLast) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                    o_d     = '0;
                    wcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (wcnt_q == NijA) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                cnt_d = '0;
                if (kij_q == KijLast) begin
                    state_d = StDone;
                    kij_d   = '0;
                end else begin
                    state_d = StWLoad;
                    kij_d   = kij_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        unique case (state_d)
            StWLoad: begin
                if (cnt_d < ColA) begin
                    inst_d[CEN_XMEM_B] = 1'b0;
                    inst_d[WEN_XMEM_B] = 1'b1;
                    inst_d[A_XMEM_MSB:A_XMEM_LSB] = w_base + AW'(kij_d) * ColA + cnt_d;
                end
                // l0_wr trails the read by one cycle for the SRAM latency
                if (cnt_d != '0) begin
                    inst_d[L0_WR_B] = 1'b1;
                end
            end
            StWPush: begin
                inst_d[L0_RD_B] = 1'b1;
                inst_d[LOAD_B]  = 1'b1;
            end
            StXLoad: begin
                if (cnt_d < NijA) begin
                    inst_d[CEN_XMEM_B] = 1'b0;
                    inst_d[WEN_XMEM_B] = 1'b1;
                    inst_d[A_XMEM_MSB:A_XMEM_LSB] = x_base + cnt_d;
                end
                if (cnt_d != '0) begin
                    inst_d[L0_WR_B] = 1'b1;
                end
            end
            StXExec: begin
                inst_d[L0_RD_B]   = 1'b1;
                inst_d[EXECUTE_B] = 1'b1;
            end
            StDrain: begin
                // Write back the row read out in the previous word
                if (inst_q[OFIFO_RD_B]) begin
                    inst_d[CEN_PMEM_B] = 1'b0;
                    inst_d[WEN_PMEM_B] = 1'b0;
                    inst_d[A_PMEM_MSB:A_PMEM_LSB] = o_q - 1'b1;
                    inst_d[ACC_B] = (kij_q != '0);
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (seq_io.ofifo_valid && (o_d < NijA)) begin
                    inst_d[OFIFO_RD_B] = 1'b1;
                    o_d = o_d + 1'b1;
                end
            end
            default: begin
                inst_d = IDLE_INST;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Sequencer state and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            o_q     <= '0;
            wcnt_q  <= '0;
            kij_q   <= '0;
            inst_q  <= IDLE_INST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            wcnt_q  <= wcnt_d;
            kij_q   <= kij_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign seq_io.inst = inst_q;
    assign seq_io.busy = busy_q;
    assign seq_io.done = done_q;
    assign seq_io.err  = err_q;

endmodule

// File: tb/tb_corelet_seq.sv
// Directed bench for corelet_seq: one instance with a single kernel index
// for the detailed checks, one with nine for the full accumulation run.
module tb_corelet_seq;
    import corelet_pkg::*;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int NIJ = 36;
    localparam int CPK = (COL + 1) + COL + (ROW + COL) + (NIJ + 1) + NIJ + (NIJ + 1) + 1;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    corelet_seq_if ifa ();
    corelet_seq_if ifb ();

    corelet_seq #(
        .row(ROW), .col(COL), .len_kij(1), .len_nij(NIJ), .w_base(11'd1024), .x_base(11'd0)
    ) dut1 (
        .clk(clk),
        .reset(reset),
        .seq_io(ifa)
    );

    corelet_seq #(
        .row(ROW), .col(COL), .len_kij(9), .len_nij(NIJ), .w_base(11'd1024), .x_base(11'd0)
    ) dut9 (
        .clk(clk),
        .reset(reset),
        .seq_io(ifb)
    );

    // Observers for dut1
    int          a_l0wr, a_rd, a_done, a_done_cyc, a_bad_rw, a_bad_valid;
    logic        a_err_at_done;
    logic [10:0] a_xq[$];
    logic [11:0] a_pq[$];
    logic        a_rd_prev = 1'b0;
    logic        a_valid_s = 1'b0;

    always @(posedge clk) a_valid_s <= ifa.ofifo_valid;

    always @(negedge clk) begin
        if (!ifa.inst[19]) a_xq.push_back(ifa.inst[17:7]);
        if (ifa.inst[2]) a_l0wr++;
        if (ifa.inst[6]) begin
            a_rd++;
            if (!a_valid_s) a_bad_valid++;
        end
        if (!ifa.inst[32] && !ifa.inst[31]) a_pq.push_back({ifa.inst[33], ifa.inst[30:20]});
        if ((!ifa.inst[32] && !ifa.inst[31]) != a_rd_prev) a_bad_rw++;
        a_rd_prev = ifa.inst[6];
        if (ifa.done) begin
            a_done++;
            a_done_cyc = cyc;
            a_err_at_done = ifa.err;
        end
    end

    // Observers for dut9
    int          b_done, b_done_cyc;
    logic [10:0] b_wq[$];
    logic [11:0] b_pq[$];

    always @(negedge clk) begin
        if (!ifb.inst[19] && (ifb.inst[17:7] >= 11'd1024)) b_wq.push_back(ifb.inst[17:7]);
        if (!ifb.inst[32] && !ifb.inst[31]) b_pq.push_back({ifb.inst[33], ifb.inst[30:20]});
        if (ifb.done) begin
            b_done++;
            b_done_cyc = cyc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_a;
        a_l0wr = 0; a_rd = 0; a_done = 0; a_done_cyc = 0;
        a_bad_rw = 0; a_bad_valid = 0; a_err_at_done = 1'b0;
        a_xq.delete();
        a_pq.delete();
    endtask

    int t0, t0b, mis;
    bit found;

    initial begin
        ifa.start = 1'b0; ifa.l0_full = 1'b0; ifa.ofifo_full = 1'b0; ifa.ofifo_valid = 1'b0;
        ifb.start = 1'b0; ifb.l0_full = 1'b0; ifb.ofifo_full = 1'b0; ifb.ofifo_valid = 1'b1;
        b_done = 0; b_done_cyc = 0;
        clr_a();

        // Reset
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_inst", 64'(ifa.inst), 64'(IDLE_W));
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_done", 64'(ifa.done), 64'd0);
        chk("rst_err", 64'(ifa.err), 64'd0);
        chk("rst_inst9", 64'(ifb.inst), 64'(IDLE_W));
        reset = 1'b0;
        tick();

        // Single kij, ofifo_valid held high, one stray start while busy
        clr_a();
        ifa.ofifo_valid = 1'b1;
        ifa.start = 1'b1;
        t0 = cyc + 1;
        tick();
        ifa.start = 1'b0;
        chk("first_busy", 64'(ifa.busy), 64'd1);
        chk("first_cen_x", 64'(ifa.inst[19]), 64'd0);
        chk("first_addr", 64'(ifa.inst[17:7]), 64'd1024);
        chk("first_l0wr", 64'(ifa.inst[2]), 64'd0);
        tick();
        chk("second_l0wr", 64'(ifa.inst[2]), 64'd1);
        repeat (20) tick();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int k = 0; k < CPK + 20 && a_done == 0; k++) tick();
        chk("s_done_seen", 64'(a_done), 64'd1);
        chk("s_done_cyc", 64'(a_done_cyc - t0), 64'(CPK));
        chk("s_busy_after", 64'(ifa.busy), 64'd0);
        chk("s_xq_size", 64'(a_xq.size()), 64'd44);
        mis = 0;
        for (int k = 0; k < a_xq.size(); k++) begin
            if (a_xq[k] != ((k < 8) ? 11'(1024 + k) : 11'(k - 8))) mis++;
        end
        chk("s_xq_seq", 64'(mis), 64'd0);
        chk("s_l0wr", 64'(a_l0wr), 64'd44);
        chk("s_pq_size", 64'(a_pq.size()), 64'd36);
        mis = 0;
        for (int k = 0; k < a_pq.size(); k++) begin
            if (a_pq[k] != {1'b0, 11'(k)}) mis++;
        end
        chk("s_pq_seq", 64'(mis), 64'd0);
        chk("s_rd", 64'(a_rd), 64'd36);
        chk("s_rw_pair", 64'(a_bad_rw), 64'd0);
        chk("s_err", 64'(ifa.err), 64'd0);

        // Gapped ofifo_valid
        clr_a();
        ifa.ofifo_valid = 1'b0;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int k = 0; k < 3 * CPK + 100 && a_done == 0; k++) begin
            tick();
            ifa.ofifo_valid = ((cyc % 3) == 0);
        end
        ifa.ofifo_valid = 1'b1;
        chk("g_done_seen", 64'(a_done), 64'd1);
        chk("g_rd", 64'(a_rd), 64'd36);
        chk("g_rd_valid", 64'(a_bad_valid), 64'd0);
        chk("g_rw_pair", 64'(a_bad_rw), 64'd0);
        chk("g_pq_size", 64'(a_pq.size()), 64'd36);
        mis = 0;
        for (int k = 0; k < a_pq.size(); k++) begin
            if (a_pq[k] != {1'b0, 11'(k)}) mis++;
        end
        chk("g_pq_seq", 64'(mis), 64'd0);

        // l0_full during XLOAD sets a sticky error
        clr_a();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (!ifa.inst[19] && (ifa.inst[17:7] == 11'd0)) found = 1'b1;
            else tick();
        end
        chk("e_xload_found", 64'(found), 64'd1);
        chk("e_err_before", 64'(ifa.err), 64'd0);
        ifa.l0_full = 1'b1;
        tick();
        tick();
        ifa.l0_full = 1'b0;
        chk("e_err_set", 64'(ifa.err), 64'd1);
        for (int k = 0; k < CPK + 20 && a_done == 0; k++) tick();
        chk("e_err_at_done", 64'(a_err_at_done), 64'd1);
        chk("e_err_idle", 64'(ifa.err), 64'd1);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("e_err_cleared", 64'(ifa.err), 64'd0);

        // Reset in the middle of XEXEC
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (ifa.inst[1]) found = 1'b1;
            else tick();
        end
        chk("r_xexec_found", 64'(found), 64'd1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("r_inst", 64'(ifa.inst), 64'(IDLE_W));
        chk("r_busy", 64'(ifa.busy), 64'd0);
        chk("r_done", 64'(ifa.done), 64'd0);
        chk("r_state", 64'(dut1.state_q), 64'(StIdle));
        reset = 1'b0;
        tick();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("r_restart_cen", 64'(ifa.inst[19]), 64'd0);
        chk("r_restart_addr", 64'(ifa.inst[17:7]), 64'd1024);

        // Full nine-kij run on the second instance
        b_wq.delete();
        b_pq.delete();
        b_done = 0;
        ifb.start = 1'b1;
        t0b = cyc + 1;
        tick();
        ifb.start = 1'b0;
        for (int k = 0; k < 9 * CPK + 50 && b_done == 0; k++) tick();
        repeat (5) tick();
        chk("f_done_count", 64'(b_done), 64'd1);
        chk("f_done_cyc", 64'(b_done_cyc - t0b), 64'(9 * CPK));
        chk("f_wq_size", 64'(b_wq.size()), 64'd72);
        mis = 0;
        for (int k = 0; k < b_wq.size(); k++) begin
            if (b_wq[k] != 11'(1024 + k)) mis++;
        end
        chk("f_wq_seq", 64'(mis), 64'd0);
        chk("f_pq_size", 64'(b_pq.size()), 64'd324);
        mis = 0;
        for (int k = 0; k < b_pq.size(); k++) begin
            if (b_pq[k] != {(k >= 36) ? 1'b1 : 1'b0, 11'(k % 36)}) mis++;
        end
        chk("f_pq_seq", 64'(mis), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
